// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Master-side reader for the single-port block RAM. A start pulse loads a
// base address and a word count; the block then issues sequential reads,
// absorbs the one-cycle BRAM read latency and downstream backpressure in a
// two-entry skid buffer, and streams the words out as AXI4-Stream beats with
// tlast on the final beat. The BRAM is never written.
//
// Optional build macro: BRAM_STREAM_SOF_EN
//   When defined, an extra m_axis_tuser output marks the first beat of every
//   job (start-of-frame). The flag travels through the skid buffer alongside
//   its data word. When undefined the port and its storage do not exist.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle job request, honoured only while busy=0
//   base_addr      first word address (< DEPTH)
//   length         number of words to read, 0..DEPTH
//   busy           high while a job is in progress
//   done           one-cycle pulse at job end
//   bram_ce        BRAM chip enable
//   bram_we        BRAM write enable, always 0
//   bram_addr      BRAM address
//   bram_rdata     BRAM read data, valid the cycle after bram_ce
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tuser   start-of-frame flag (BRAM_STREAM_SOF_EN only)
//   m_axis_tlast   last beat of the job
// ---------------------------------------------------------------------------
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_ce,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef BRAM_STREAM_SOF_EN
  output logic                  m_axis_tuser,
`endif
  output logic                  m_axis_tlast
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         ONE_W     = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         popped_q;
  logic                  rd_pending_q;
  logic                  done_q;
  logic                  done_next;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

`ifdef BRAM_STREAM_SOF_EN
  logic                  buf_user [2];
  logic [CW-1:0]         pushed_q;
`endif

  logic       accept;
  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] credit_used;

  // Handshake and credit bookkeeping. A slot is "used" by every read still
  // in flight and every word sitting in the buffer; a pop in this cycle
  // returns its slot immediately so a new read can go out in the same cycle,
  // which is what keeps the stream bubble-free with tready held high.
  always_comb begin
    accept      = (state_q == IDLE) && start;
    push        = rd_pending_q;
    pop         = m_axis_tvalid && m_axis_tready;
    credit_used = 2'(rd_pending_q) + count_q - 2'(pop);
    issue       = (state_q == READ) && (credit_used < 2'd2) && (issued_q < len_q);
  end

  // Next-state logic. A zero-length job never leaves IDLE; it only pulses
  // done. DRAIN ends on the handshake of the final beat.
  always_comb begin
    state_next = state_q;
    done_next  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (issue && (issued_q + ONE_W == len_q)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (popped_q + ONE_W == len_q)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and job counters. The address wraps by comparing against
  // DEPTH-1 because DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_next;
      done_q       <= done_next;
      rd_pending_q <= issue;
      if (accept) begin
        addr_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          issued_q <= issued_q + ONE_W;
        end
        if (pop) begin
          popped_q <= popped_q + ONE_W;
        end
      end
    end
  end

  // Two-entry skid buffer. Capture of returning read data is unconditional:
  // the credit check above guarantees a free slot whenever a read returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr_q] <= bram_rdata;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

`ifdef BRAM_STREAM_SOF_EN
  // Start-of-frame flag: the first word pushed in a job carries tuser=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_user[0] <= 1'b0;
      buf_user[1] <= 1'b0;
      pushed_q    <= '0;
    end else begin
      if (accept) begin
        pushed_q <= '0;
      end else if (push) begin
        pushed_q <= pushed_q + ONE_W;
      end
      if (push) begin
        buf_user[wr_ptr_q] <= (pushed_q == '0);
      end
    end
  end

  assign m_axis_tuser = m_axis_tvalid && buf_user[rd_ptr_q];
`endif

  // Output drive. The head of the buffer holds word index popped_q, so tlast
  // is derived from the pop count rather than stored per entry.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = done_q;
    bram_ce       = issue;
    bram_we       = 1'b0;
    bram_addr     = addr_q;
    m_axis_tvalid = (count_q != 2'd0);
    m_axis_tdata  = buf_data[rd_ptr_q];
    m_axis_tlast  = m_axis_tvalid && (popped_q == len_q - ONE_W);
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A behavioural BRAM model
// answers reads one cycle after bram_ce. Each job's expected beat list is
// computed directly from memory contents, base address and length
// (word i = mem[(base+i) mod DEPTH], tlast on i=length-1, tuser on i=0),
// and every observed beat, address and timing point is compared against it.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 48;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          bram_ce;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
`ifdef BRAM_STREAM_SOF_EN
  logic          m_axis_tuser;
`endif

  logic [DW-1:0] mem [DEPTH];
  bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int total;
  int bad;

  bram_stream_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .bram_ce      (bram_ce),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_rdata   (bram_rdata),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
`ifdef BRAM_STREAM_SOF_EN
    .m_axis_tuser (m_axis_tuser),
`endif
    .m_axis_tlast (m_axis_tlast)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port BRAM with one cycle of read latency
  initial bram_rdata = '0;
  always @(posedge clk) begin
    if (bram_ce) begin
      if (int'(bram_addr) < DEPTH) bram_rdata <= mem[bram_addr];
      else bram_rdata <= 'x;
    end
  end

  // Runs one job and checks beats, addresses, credit limit, stall stability,
  // latency, throughput (mode 0), and the done/busy timing.
  // mode: 0 tready=1, 1 fixed toggle pattern, 2 random tready.
  task automatic run_job(input logic [AW-1:0] base, input logic [AW:0] len,
                         input int mode, input bit inject, input string name);
    logic [DW-1:0] exp_data [64];
    logic [DW-1:0] want;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            prev_stall;
    bit            finished;
    bit            want_last;
    int n_issued, n_beats, first_ce, first_valid, first_hs, last_hs, done_c;
    for (int i = 0; i < int'(len); i++) exp_data[i] = mem[(int'(base) + i) % DEPTH];
    n_issued = 0; n_beats = 0; first_ce = -1; first_valid = -1;
    first_hs = -1; last_hs = -1; done_c = -1;
    prev_stall = 0; prev_data = '0; prev_last = 0; finished = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len; m_axis_tready = 1'b1;
    for (int c = 1; c <= 600 && !finished; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && (c == 2 || c == 4)) begin
        start = 1'b1; base_addr = 6'd0; length = 7'd3;
      end
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = pat[(c - 1) % 6];
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      total++;
      if (bram_we !== 1'b0) begin
        bad++; $display("[TB] FAIL %s we c%0d: got %b want 0", name, c, bram_we);
      end
      if (bram_ce === 1'b1) begin
        if (first_ce < 0) first_ce = c;
        total++;
        if (n_issued >= int'(len) || bram_addr !== AW'((int'(base) + n_issued) % DEPTH)) begin
          bad++;
          $display("[TB] FAIL %s addr read%0d: got %0d want %0d (len %0d)", name, n_issued,
                   bram_addr, (int'(base) + n_issued) % DEPTH, len);
        end
        n_issued++;
      end
      if (prev_stall) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          bad++;
          $display("[TB] FAIL %s stall c%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", name, c,
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid === 1'b1 && first_valid < 0) first_valid = c;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (first_hs < 0) first_hs = c;
        last_hs   = c;
        want      = (n_beats < int'(len)) ? exp_data[n_beats] : 'x;
        want_last = (n_beats == int'(len) - 1);
        total++;
        if (n_beats >= int'(len) || m_axis_tdata !== want || m_axis_tlast !== want_last) begin
          bad++;
          $display("[TB] FAIL %s beat%0d: got d=%h l=%b want d=%h l=%b", name, n_beats,
                   m_axis_tdata, m_axis_tlast, want, want_last);
        end
`ifdef BRAM_STREAM_SOF_EN
        total++;
        if (m_axis_tuser !== (n_beats == 0)) begin
          bad++;
          $display("[TB] FAIL %s tuser beat%0d: got %b want %b", name, n_beats,
                   m_axis_tuser, (n_beats == 0));
        end
`endif
        n_beats++;
      end
      total++;
      if (n_issued - n_beats > 2) begin
        bad++;
        $display("[TB] FAIL %s credit c%0d: got %0d outstanding want <=2", name, c, n_issued - n_beats);
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (done === 1'b1) begin
        done_c   = c;
        finished = 1;
        total++;
        if (busy !== 1'b0) begin
          bad++; $display("[TB] FAIL %s busy at done: got %b want 0", name, busy);
        end
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("[TB] FAIL %s busy c%0d: got %b want 1", name, c, busy);
        end
      end
    end
    start = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("[TB] FAIL %s timeout: got no done want done within 600 cycles", name);
    end
    total++;
    if (n_beats != int'(len) || n_issued != int'(len)) begin
      bad++;
      $display("[TB] FAIL %s counts: got beats=%0d reads=%0d want %0d", name, n_beats, n_issued, len);
    end
    if (len == '0) begin
      total++;
      if (first_ce >= 0 || first_valid >= 0 || done_c != 1) begin
        bad++;
        $display("[TB] FAIL %s zero-length: got ce@%0d valid@%0d done@%0d want none,none,1",
                 name, first_ce, first_valid, done_c);
      end
    end else begin
      total++;
      if (first_ce != 1) begin
        bad++; $display("[TB] FAIL %s first ce: got c%0d want c1", name, first_ce);
      end
      total++;
      if (first_valid != 3) begin
        bad++; $display("[TB] FAIL %s first tvalid: got c%0d want c3", name, first_valid);
      end
      total++;
      if (done_c != last_hs + 1) begin
        bad++; $display("[TB] FAIL %s done timing: got c%0d want c%0d", name, done_c, last_hs + 1);
      end
      if (mode == 0) begin
        total++;
        if (last_hs - first_hs != int'(len) - 1) begin
          bad++;
          $display("[TB] FAIL %s throughput: got span %0d want %0d", name, last_hs - first_hs, int'(len) - 1);
        end
      end
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL %s after done: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  // Reset values
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset busy/done: got %b %b want 0 0", busy, done);
    end
    total++;
    if (bram_ce !== 1'b0 || bram_addr !== '0 || bram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL reset bram: got ce=%b addr=%0d we=%b want 0 0 0", bram_ce, bram_addr, bram_we);
    end
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
      bad++;
      $display("[TB] FAIL reset stream: got v=%b l=%b d=%h want 0 0 00", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
`ifdef BRAM_STREAM_SOF_EN
    total++;
    if (m_axis_tuser !== 1'b0) begin
      bad++; $display("[TB] FAIL reset tuser: got %b want 0", m_axis_tuser);
    end
`endif
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    run_job(6'd5, 7'd4, 0, 0, "basic");
  endtask

  task automatic test_wrap();
    run_job(6'd46, 7'd5, 0, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_job(6'd20, 7'd6, 1, 0, "backpressure");
    run_job(6'd40, 7'd17, 1, 0, "backpressure_wrap");
  endtask

  task automatic test_edges();
    run_job(6'd9, 7'd0, 0, 0, "len0");
    run_job(6'd0, 7'd48, 0, 0, "len48");
    run_job(6'd47, 7'd1, 0, 0, "len1");
    run_job(6'd7, 7'd3, 0, 0, "len3");
  endtask

  task automatic test_start_while_busy();
    run_job(6'd12, 7'd8, 0, 1, "start_busy");
  endtask

  // Reset after two beats of an eight-beat job, then a fresh job
  task automatic test_reset_mid_job();
    int hs;
    hs = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd10; length = 7'd8; m_axis_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        total++;
        if (m_axis_tdata !== mem[10 + hs]) begin
          bad++; $display("[TB] FAIL rst_mid beat%0d: got %h want %h", hs, m_axis_tdata, mem[10 + hs]);
        end
        hs++;
      end
      if (hs >= 2) break;
    end
    total++;
    if (hs < 2) begin
      bad++; $display("[TB] FAIL rst_mid timeout: got %0d beats want 2", hs);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bram_ce !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid abort: got v=%b busy=%b done=%b ce=%b want 0 0 0 0",
               m_axis_tvalid, busy, done, bram_ce);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (m_axis_tvalid !== 1'b0 || done !== 1'b0 || bram_ce !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_mid quiet c%0d: got v=%b done=%b ce=%b want 0 0 0",
                 c, m_axis_tvalid, done, bram_ce);
      end
    end
    run_job(6'd3, 7'd6, 0, 0, "after_reset");
  endtask

  // Random memory contents, base, length and tready
  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    for (int j = 0; j < 12; j++) begin
      run_job(6'($urandom_range(0, DEPTH - 1)), 7'($urandom_range(0, DEPTH)), 2, 0, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edges();
    test_start_while_busy();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Master-side reader for the team's single-port block RAM: drives its ce/we/addr pins and streams the read words out as AXI4-Stream beats, for example toward the DMA S2MM path.
- A start pulse loads a base address and a word count. The block then issues sequential reads, absorbs the 1-cycle BRAM read latency and downstream backpressure in a 2-entry skid buffer, and marks the final beat with tlast.
- It never writes to the BRAM.

Parameters:
- ADDR_WIDTH, 6, width of the BRAM address and of base_addr.
- DATA_WIDTH, 8, width of the BRAM word and of m_axis_tdata.
- DEPTH, 48, number of BRAM words. Addresses wrap modulo DEPTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only when busy=0.
- base_addr  in  ADDR_WIDTH  first word address; must be < DEPTH.
- length  in  ADDR_WIDTH+1  words to read, 0..DEPTH.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high.
- done  out  1  one-cycle pulse at job end.
- bram_ce  out  1  BRAM chip enable.
- bram_we  out  1  tied to 0.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_rdata  in  DATA_WIDTH  BRAM o_data, valid the cycle after ce=1.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the last beat of the job.

Behaviour:
- Reset values: busy=0, done=0, bram_ce=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. The FSM returns to IDLE and the skid buffer is emptied.
- Reset mid-job aborts immediately: no further beats and no done pulse.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - On start=1, capture base_addr and length, then go to READ.
  - If length=0, go to DONE behaviour directly: done=1 next cycle, no BRAM access, no beats.
- READ:
  - bram_ce=1 in a cycle only when (reads in flight + words in buffer) < 2 and the issued-read count < length.
  - bram_addr starts at base_addr and increments by 1 after each issued read. DEPTH-1 wraps to 0; this is a compare, not a power-of-two mask.
  - When issued-read count reaches length, go to DRAIN.
- Read capture: a read issued in cycle n presents bram_rdata in cycle n+1, which is written into the skid buffer at the end of n+1. Capture is unconditional; the credit rule guarantees the buffer has room.
- Output side:
  - m_axis_tvalid is high whenever the buffer is non-empty; the head entry drives tdata.
  - A beat transfers on tvalid & tready.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- tlast is high when the head entry is word index length-1.
- DRAIN: wait until all `length` beats have transferred, then assert done=1 for one cycle, set busy=0, and go to IDLE.
- A start arriving while busy=1 is ignored; no queuing.
- Latency: start accepted at edge k, first bram_ce in cycle k+1, first tvalid in cycle k+3.
- Throughput: with tready held at 1, one beat per cycle, no bubbles.
- Simultaneous events: a buffer push and pop in the same cycle keep the occupancy unchanged. A read may issue in the same cycle a pop frees a credit.
- Word counters are ADDR_WIDTH+1 bits wide so that length=DEPTH is exact.

Optional Feature:
- Macro: BRAM_STREAM_SOF_EN.
- Defined:
  - Extra output port m_axis_tuser (1 bit).
  - Driven high on the first beat of each job (word index 0), including a 1-beat job where tlast is also high.
  - Carried through the skid buffer with its data.
  - Reset value 0.
- Undefined: the port does not exist and no tuser storage is built.

Test Plan:
- Basic job: DEPTH=48, BRAM preloaded mem[i]=i; base_addr=5, length=4, tready=1 -> beats 05,06,07,08 on consecutive cycles, tlast on 08, first tvalid 3 cycles after start, done one cycle after last handshake.
- Wrap: base_addr=46, length=5 -> bram_addr sequence 46,47,0,1,2; beats 2E,2F,00,01,02.
- Backpressure: length=6 with tready toggling 1,0,0,1,0,1... -> exactly 6 beats in order, no duplicates or drops, tdata stable during stalls, never more than 2 reads outstanding or buffered.
- Edges: length=0 -> done pulse, no bram_ce, no tvalid. length=48, base_addr=0 -> all 48 words, tlast only on 2F.
- Start while busy and reset mid-job: start again mid-job is ignored. Asserting rst after 2 of 8 beats -> tvalid=0 and busy=0 next cycle, no done pulse. A new job afterwards streams correctly.
- With BRAM_STREAM_SOF_EN defined: length=3 -> tuser=1 only on beat 0. length=1 -> tuser=1 and tlast=1 on the single beat.
